// File: rtl/fpmul_rr_arbiter.sv
// Round-robin arbiter sharing one 12-bit FP multiplier between N requesters.
// Optional per-requester grant counters: define FPMUL_RR_ARBITER_STATS_EN.
module fpmul_rr_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned MUL_LATENCY = 1,
    parameter int unsigned IDW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [N-1:0]      i_req_valid,
    input  logic [N*12-1:0]   i_req_a,
    input  logic [N*12-1:0]   i_req_b,
    output logic [N-1:0]      o_req_ready,
    output logic [11:0]       o_mul_a,
    output logic [11:0]       o_mul_b,
    output logic              o_mul_valid_in,
    input  logic [11:0]       i_mul_result,
    input  logic              i_mul_valid_out,
    output logic [N-1:0]      o_rsp_valid,
    output logic [11:0]       o_rsp_result,
    output logic [IDW-1:0]    o_rsp_id,
    output logic              o_busy,
    output logic              o_err
`ifdef FPMUL_RR_ARBITER_STATS_EN
    ,
    input  logic              i_stats_clr,
    output logic [N*16-1:0]   o_grant_cnt
`endif
);

    logic [IDW-1:0] r_ptr;
    logic [11:0]    r_mul_a;
    logic [11:0]    r_mul_b;
    logic           r_mul_vld;
    logic [IDW-1:0] r_mul_id;
    logic           r_tag_vld [MUL_LATENCY];
    logic [IDW-1:0] r_tag_id  [MUL_LATENCY];
    logic           r_err;

    logic [N-1:0]   w_ready;
    logic [IDW-1:0] w_gnt_id;
    logic [IDW-1:0] w_idx;
    logic           w_found;
    logic           w_hs;
    logic [IDW-1:0] w_ptr_next;
    logic           w_head_vld;
    logic [IDW-1:0] w_head_id;
    logic           w_busy;

    // Search p, p+1, ..., wrapping; first valid requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % int'(N));
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
        w_ready = '0;
        if (w_found && i_en && !i_rst) begin
            w_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_hs       = |w_ready;
    assign w_ptr_next = (w_gnt_id == IDW'(N - 1)) ? '0 : w_gnt_id + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr     <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_mul_vld <= 1'b0;
            r_mul_id  <= '0;
        end else begin
            r_mul_vld <= w_hs;
            if (w_hs) begin
                r_mul_a  <= i_req_a[w_gnt_id*12 +: 12];
                r_mul_b  <= i_req_b[w_gnt_id*12 +: 12];
                r_mul_id <= w_gnt_id;
                r_ptr    <= w_ptr_next;
            end
        end
    end

    // Tag pipe mirrors the multiplier latency so the head lines up with mul_valid_out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < int'(MUL_LATENCY); s++) begin
                r_tag_vld[s] <= 1'b0;
                r_tag_id[s]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_mul_vld;
            r_tag_id[0]  <= r_mul_id;
            for (int s = 1; s < int'(MUL_LATENCY); s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    assign w_head_vld = r_tag_vld[MUL_LATENCY-1];
    assign w_head_id  = r_tag_id[MUL_LATENCY-1];

    always_comb begin
        o_rsp_valid  = '0;
        o_rsp_id     = '0;
        o_rsp_result = '0;
        if (i_mul_valid_out && w_head_vld) begin
            o_rsp_valid[w_head_id] = 1'b1;
            o_rsp_id               = w_head_id;
            o_rsp_result           = i_mul_result;
        end
    end

    always_comb begin
        w_busy = r_mul_vld;
        for (int s = 0; s < int'(MUL_LATENCY); s++) begin
            w_busy = w_busy | r_tag_vld[s];
        end
    end

    // Any disagreement between the tag head and the multiplier strobe is sticky.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (i_mul_valid_out != w_head_vld) begin
            r_err <= 1'b1;
        end
    end

    assign o_req_ready    = w_ready;
    assign o_mul_a        = r_mul_a;
    assign o_mul_b        = r_mul_b;
    assign o_mul_valid_in = r_mul_vld;
    assign o_busy         = w_busy;
    assign o_err          = r_err;

`ifdef FPMUL_RR_ARBITER_STATS_EN
    logic [15:0] r_grant_cnt [N];

    // Clear wins over a same-cycle grant; counts saturate at 16'hFFFF.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(N); i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (i_stats_clr) begin
                    r_grant_cnt[i] <= '0;
                end else if (w_ready[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < int'(N); gi++) begin : g_cnt
        assign o_grant_cnt[gi*16 +: 16] = r_grant_cnt[gi];
    end
`endif

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// Bench for fpmul_rr_arbiter: behavioural multiplier plus a queue-based reference model.
// Grant counters are exercised when FPMUL_RR_ARBITER_STATS_EN is defined.
module tb_fpmul_rr_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned L   = 1;
    localparam int unsigned IDW = 2;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_en;
    logic [N-1:0]      i_req_valid;
    logic [N*12-1:0]   i_req_a;
    logic [N*12-1:0]   i_req_b;
    logic [N-1:0]      o_req_ready;
    logic [11:0]       o_mul_a;
    logic [11:0]       o_mul_b;
    logic              o_mul_valid_in;
    logic [11:0]       i_mul_result;
    logic              i_mul_valid_out;
    logic [N-1:0]      o_rsp_valid;
    logic [11:0]       o_rsp_result;
    logic [IDW-1:0]    o_rsp_id;
    logic              o_busy;
    logic              o_err;
`ifdef FPMUL_RR_ARBITER_STATS_EN
    logic              i_stats_clr;
    logic [N*16-1:0]   o_grant_cnt;
`endif

    fpmul_rr_arbiter #(
        .N           (N),
        .MUL_LATENCY (L)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_en            (i_en),
        .i_req_valid     (i_req_valid),
        .i_req_a         (i_req_a),
        .i_req_b         (i_req_b),
        .o_req_ready     (o_req_ready),
        .o_mul_a         (o_mul_a),
        .o_mul_b         (o_mul_b),
        .o_mul_valid_in  (o_mul_valid_in),
        .i_mul_result    (i_mul_result),
        .i_mul_valid_out (i_mul_valid_out),
        .o_rsp_valid     (o_rsp_valid),
        .o_rsp_result    (o_rsp_result),
        .o_rsp_id        (o_rsp_id),
        .o_busy          (o_busy),
        .o_err           (o_err)
`ifdef FPMUL_RR_ARBITER_STATS_EN
        ,
        .i_stats_clr     (i_stats_clr),
        .o_grant_cnt     (o_grant_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          due;
        int          id;
        logic [11:0] res;
    } exp_t;

    exp_t        exp_q[$];
    int          ptr;
    bit          err_exp;
    int          cyc;
    int          cnt[N];
    int          n_checks;
    int          n_pass;
    logic        mp_vld [L];
    logic [11:0] mp_res [L];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    endtask

    // 1/5/6 format, bias 15, denormals as zero, truncating, saturating.
    function automatic logic [11:0] fpmul(input logic [11:0] a, input logic [11:0] b);
        int   ea, eb, e, m;
        logic s;
        s  = a[11] ^ b[11];
        ea = int'(a[10:6]);
        eb = int'(b[10:6]);
        if (ea == 0 || eb == 0) return {s, 11'd0};
        m = (64 + int'(a[5:0])) * (64 + int'(b[5:0]));
        e = ea + eb - 15;
        if (m >= 8192) begin
            e++;
            m = m >> 7;
        end else begin
            m = m >> 6;
        end
        if (e <= 0) return {s, 11'd0};
        if (e >= 31) return {s, 5'd30, 6'h3F};
        return {s, e[4:0], m[5:0]};
    endfunction

    task automatic clear_model();
        exp_q.delete();
        ptr     = 0;
        err_exp = 1'b0;
        for (int i = 0; i < int'(N); i++) cnt[i] = 0;
        for (int s = 0; s < int'(L); s++) begin
            mp_vld[s] = 1'b0;
            mp_res[s] = '0;
        end
    endtask

    task automatic do_reset();
        i_rst       = 1'b1;
        i_en        = 1'b0;
        i_req_valid = '0;
`ifdef FPMUL_RR_ARBITER_STATS_EN
        i_stats_clr = 1'b0;
`endif
        clear_model();
        i_mul_valid_out = 1'b0;
        #1;
        check("rst_ready", o_req_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_result", o_rsp_result, 0);
        check("rst_rsp_id", o_rsp_id, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        check("rst_mul_vld", o_mul_valid_in, 0);
        check("rst_mul_a", o_mul_a, 0);
        check("rst_mul_b", o_mul_b, 0);
        @(posedge i_clk);
        cyc++;
        #1;
        i_rst = 1'b0;
    endtask

    task automatic tick(input logic en, input logic [N-1:0] vld, input logic [N*12-1:0] a,
                        input logic [N*12-1:0] b, input logic clr);
        logic [N-1:0] exp_rdy;
        int           g;
        int           idx;
        bit           due;
        logic         mv;
        logic [11:0]  ma, mb;
        i_en        = en;
        i_req_valid = vld;
        i_req_a     = a;
        i_req_b     = b;
`ifdef FPMUL_RR_ARBITER_STATS_EN
        i_stats_clr = clr;
`endif
        #1;
        g = -1;
        if (en) begin
            for (int k = 0; k < int'(N); k++) begin
                idx = (ptr + k) % int'(N);
                if (g < 0 && vld[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("ready", o_req_ready, exp_rdy);
        check("busy", o_busy, exp_q.size() > 0);
        check("err", o_err, err_exp);
        due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (due && i_mul_valid_out) begin
            check("rsp_valid", o_rsp_valid, 32'd1 << exp_q[0].id);
            check("rsp_id", o_rsp_id, exp_q[0].id);
            check("rsp_result", o_rsp_result, exp_q[0].res);
        end else begin
            check("rsp_valid_idle", o_rsp_valid, 0);
            check("rsp_id_idle", o_rsp_id, 0);
            check("rsp_result_idle", o_rsp_result, 0);
        end
`ifdef FPMUL_RR_ARBITER_STATS_EN
        for (int i = 0; i < int'(N); i++) check("grant_cnt", o_grant_cnt[i*16 +: 16], cnt[i]);
        for (int i = 0; i < int'(N); i++) begin
            if (clr) cnt[i] = 0;
            else if (i == g && cnt[i] < 65535) cnt[i]++;
        end
`endif
        if (i_mul_valid_out != due) err_exp = 1'b1;
        if (due) void'(exp_q.pop_front());
        if (g >= 0) begin
            exp_q.push_back('{due: cyc + 1 + int'(L), id: g,
                              res: fpmul(a[g*12 +: 12], b[g*12 +: 12])});
            ptr = (g + 1) % int'(N);
        end
        mv = o_mul_valid_in;
        ma = o_mul_a;
        mb = o_mul_b;
        @(posedge i_clk);
        cyc++;
        #1;
        for (int s = int'(L) - 1; s > 0; s--) begin
            mp_vld[s] = mp_vld[s-1];
            mp_res[s] = mp_res[s-1];
        end
        mp_vld[0]       = mv;
        mp_res[0]       = fpmul(ma, mb);
        i_mul_valid_out = mp_vld[L-1];
        i_mul_result    = mp_res[L-1];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, '0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [N*12-1:0] pa, pb;
        n_checks        = 0;
        n_pass          = 0;
        cyc             = 0;
        i_mul_valid_out = 1'b0;
        i_mul_result    = '0;
        i_req_a         = '0;
        i_req_b         = '0;
        #2;
        do_reset();

        // Single op from requester 2: 1.0 * 2.0
        pa = '0;
        pb = '0;
        pa[2*12 +: 12] = 12'h3C0;
        pb[2*12 +: 12] = 12'h400;
        tick(1'b1, 4'b0100, pa, pb, 1'b0);
        idle(4);

        // All four requesting from a fresh pointer: order 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < int'(N); i++) begin
            pa[i*12 +: 12] = 12'h3C0 + 12'(i);
            pb[i*12 +: 12] = 12'h400 + 12'(i * 3);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 4'b1111, pa, pb, 1'b0);
        idle(3);

        // Requester 1 then requester 3, back-to-back
        pa = '0;
        pb = '0;
        pa[1*12 +: 12] = 12'h3D0;
        pb[1*12 +: 12] = 12'h3D0;
        pa[3*12 +: 12] = 12'h3C0;
        pb[3*12 +: 12] = 12'hBC0;
        tick(1'b1, 4'b0010, pa, pb, 1'b0);
        tick(1'b1, 4'b1000, pa, pb, 1'b0);
        idle(3);

        // en dropped after two grants with everyone requesting
        for (int i = 0; i < 2; i++) tick(1'b1, 4'b1111, pa, pb, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 4'b1111, pa, pb, 1'b0);

        // Reset with an op in flight, then a stray multiplier strobe
        tick(1'b1, 4'b0001, pa, pb, 1'b0);
        do_reset();
        idle(1);
        i_mul_valid_out = 1'b1;
        i_mul_result    = 12'h123;
        tick(1'b0, '0, '0, '0, 1'b0);
        idle(3);

        // Grant counting and clear-wins
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 4'b0001, pa, pb, 1'b0);
`ifdef FPMUL_RR_ARBITER_STATS_EN
        check("cnt_five", o_grant_cnt[15:0], 5);
`endif
        tick(1'b1, 4'b0001, pa, pb, 1'b1);
`ifdef FPMUL_RR_ARBITER_STATS_EN
        check("cnt_cleared", o_grant_cnt[15:0], 0);
`endif
        idle(3);

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < int'(N); i++) begin
                pa[i*12 +: 12] = 12'($urandom);
                pb[i*12 +: 12] = 12'($urandom);
            end
            tick($urandom_range(0, 9) != 0, 4'($urandom), pa, pb, $urandom_range(0, 49) == 0);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpmul_rr_arbiter.md
Name: fpmul_rr_arbiter

Overview:
- Shares one 12-bit floating_point_multiplier instance (1 sign, 5 exp, 6 frac, bias 15) between N requesters using round-robin arbitration.
- Registers the granted operands into the multiplier and carries a requester tag through a shift pipe that matches the multiplier latency.
- Routes each result back to the requester that issued it.
- Sits between the compute-lane front ends and the shared multiplier.

Parameters:
- N, 4, number of requesters (1..16).
- MUL_LATENCY, 1, cycles from mul_valid_in sampled to mul_valid_out/mul_result valid (1..8).
- IDW, (N>1 ? $clog2(N) : 1), width of requester id (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  issue enable; when low no new grants, in-flight ops still complete.
- req_valid  in  N  per-requester operation request.
- req_a  in  N*12  packed operand A; requester i uses bits [12i+11:12i].
- req_b  in  N*12  packed operand B, same packing.
- req_ready  out  N  one-hot grant; handshake when req_valid[i] & req_ready[i].
- mul_a  out  12  registered operand A to multiplier.
- mul_b  out  12  registered operand B to multiplier.
- mul_valid_in  out  1  registered issue strobe to multiplier.
- mul_result  in  12  multiplier result.
- mul_valid_out  in  1  multiplier result strobe.
- rsp_valid  out  N  one-hot response strobe; no backpressure.
- rsp_result  out  12  result, broadcast to all requesters.
- rsp_id  out  IDW  id of the responding requester.
- busy  out  1  high while any tag is in flight or mul_valid_in is high.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst=1): mul_a=0, mul_b=0, mul_valid_in=0, tag pipe all invalid, rr pointer=0, err=0.
  - Combinational outputs then evaluate to req_ready=0, rsp_valid=0, rsp_result=0, rsp_id=0, busy=0.
  - Reset mid-operation discards in-flight tags. Multiplier outputs arriving after reset release with no valid tag set err.
- Arbitration, combinational:
  - Search starts at rr pointer p and proceeds p, p+1, …, N-1, 0, …, p-1.
  - The first i with req_valid[i] gets req_ready[i]=1.
  - req_ready is all zero when en=0 or rst=1.
  - At most one bit of req_ready is high.
- Pointer update: on a handshake from requester g, p <= (g+1) mod N at that edge. The pointer holds otherwise.
- Issue:
  - On handshake edge E: mul_a/mul_b <= granted operands, mul_valid_in <= 1.
  - With no handshake: mul_valid_in <= 0 and mul_a/mul_b hold.
  - One op per cycle at most, so back-to-back grants give full throughput.
- Tag pipe:
  - MUL_LATENCY stages of {valid, id}, shifted every cycle.
  - Stage 0 loads {mul_valid_in, id of the op currently on mul_a/mul_b}.
  - Head = last stage; it aligns with mul_valid_out.
- Response, combinational:
  - When mul_valid_out=1 and head valid: rsp_valid = one-hot(head id), rsp_id = head id, rsp_result = mul_result.
  - Otherwise rsp_valid=0, rsp_id=0, rsp_result=0.
- Latency: handshake edge E gives rsp_valid visible in the cycle after edge E+MUL_LATENCY, i.e. 1+MUL_LATENCY cycles.
- The result value is whatever the multiplier returns (underflow-to-zero, saturation, denormal-as-zero are the multiplier's job). The arbiter never alters data.
- Error conditions, each sets err at the next edge; err clears only on rst:
  - mul_valid_out=1 with head invalid.
  - Head valid with mul_valid_out=0.
- Simultaneous events: a response and a new grant in the same cycle are independent. A requester may receive a response and a grant in the same cycle.
- en deasserted mid-burst: no further grants; tags drain; busy falls MUL_LATENCY+1 cycles after the last handshake.

Optional Feature:
- Macro: FPMUL_RR_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt (N*16, packed per requester): a 16-bit saturating count of handshakes per requester, reset to 0 by rst.
  - Adds input stats_clr (1): synchronous clear of all counters. A grant in the same cycle as stats_clr counts 0, i.e. clear wins.
- Not defined: neither port exists and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Single op, MUL_LATENCY=1: requester 2 sends a=0x3C0 (1.0), b=0x400 (2.0) -> req_ready=0b0100 same cycle; rsp_valid=0b0100, rsp_id=2, rsp_result=0x400 two cycles after the handshake edge; busy low afterward.
- All four requesters held valid for 8 cycles with en=1, p=0 after reset -> grant order 0,1,2,3,0,1,2,3; responses return in the same order, each tagged with the correct rsp_id.
- Requester 1 sends 0x3D0*0x3D0 and requester 3 sends 0x3C0*0xBC0 back-to-back -> rsp_result 0x3E4 on id 1, then 0xBC0 on id 3, on consecutive cycles.
- Drop en after 2 grants with all requesting -> req_ready=0 from the next cycle; both results still delivered; busy=0 at MUL_LATENCY+1 cycles after the last handshake.
- Assert rst while 1 op is in flight, release it, then inject mul_valid_out=1 -> err=1 and stays 1 until the next rst; rsp_valid remains 0.
- With FPMUL_RR_ARBITER_STATS_EN, 5 grants to requester 0 then stats_clr=1 -> grant_cnt[15:0] reads 5, then 0.
